apb_completer_mem: RTL and testbench



---
 rtl/bridge_utils.sv | 11 +
 rtl/apb_completer_regfile.sv | 40 ++++
 rtl/apb_completer_mem.sv | 138 +++++++++++++
 tb/tb_apb_completer_mem.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_utils.sv
// Shared types for the APB completer: the transfer FSM state and the wait-counter width.
package bridge_utils;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_cmp_state_t;

  localparam int APB_CMP_WAIT_W = 4;

endpackage

// File: rtl/apb_completer_regfile.sv
// DEPTH x DATA_WIDTH word array: synchronous clear, one byte-enabled write port,
// one combinational read port.
module apb_completer_regfile
  import bridge_utils::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IDX_W-1:0]        widx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_W-1:0]        ridx,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) begin
          mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_completer_mem.sv
// APB completer backed by a word array, with fixed wait states and PSLVERR on bad addresses.
// Define APB_COMPLETER_PSTRB_EN for the APB4 pstrb port and byte-lane writes.
module apb_completer_mem
  import bridge_utils::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_COMPLETER_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0]     SPAN       = ADDR_WIDTH'(DEPTH * BYTES);
  localparam logic [ADDR_WIDTH-1:0]     ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [APB_CMP_WAIT_W-1:0] WAIT_CNT   = APB_CMP_WAIT_W'(WAIT_STATES);
  localparam logic [APB_CMP_WAIT_W-1:0] CNT_ONE    = APB_CMP_WAIT_W'(1);

  if (WAIT_STATES < 0 || WAIT_STATES >= (1 << APB_CMP_WAIT_W)) begin : g_bad_wait
    $error("apb_completer_mem: WAIT_STATES=%0d outside 0..15", WAIT_STATES);
  end

  apb_cmp_state_t              state;
  logic [APB_CMP_WAIT_W-1:0]   cnt;
  logic                        lat_write;
  logic                        lat_err;
  logic [IDX_W-1:0]            lat_idx;
  logic [DATA_WIDTH-1:0]       lat_wdata;
  logic [BYTES-1:0]            lat_strb;

  logic [ADDR_WIDTH-1:0]       off;
  logic                        dec_err;
  logic [IDX_W-1:0]            dec_idx;
  logic [IDX_W-1:0]            rd_idx;
  logic [DATA_WIDTH-1:0]       rd_data;
  logic                        commit;
  logic [BYTES-1:0]            strb_in;

`ifdef APB_COMPLETER_PSTRB_EN
  assign strb_in = pstrb;
`else
  assign strb_in = '1;
`endif

  // Offset wraps below BASE_ADDR, so one unsigned compare covers both range ends.
  always_comb begin
    off     = paddr - BASE_ADDR;
    dec_err = (off >= SPAN) || ((paddr & ALIGN_MASK) != '0);
    dec_idx = IDX_W'(off >> OFF_W);
    rd_idx  = (state == IDLE) ? dec_idx : lat_idx;
    commit  = (state == ACCESS) && (cnt == '0) && psel && penable && lat_write && !lat_err;
  end

  // Outputs are registered one edge ahead of the completion cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_strb  <= '0;
      pready    <= 1'b0;
      prdata    <= '0;
      pslverr   <= 1'b0;
    end else begin
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state     <= ACCESS;
            cnt       <= WAIT_CNT;
            lat_write <= pwrite;
            lat_err   <= dec_err;
            lat_idx   <= dec_idx;
            lat_wdata <= pwdata;
            lat_strb  <= strb_in;
            if (WAIT_STATES == 0) begin
              pready  <= 1'b1;
              pslverr <= dec_err;
              prdata  <= (!pwrite && !dec_err) ? rd_data : '0;
            end
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              pready  <= 1'b1;
              pslverr <= lat_err;
              prdata  <= (!lat_write && !lat_err) ? rd_data : '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_completer_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (commit),
    .widx  (lat_idx),
    .wdata (lat_wdata),
    .wstrb (lat_strb),
    .ridx  (rd_idx),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_apb_completer_mem.sv
// Bench for apb_completer_mem: three instances (WAIT_STATES 1/0/3) checked against a word-array model.
module tb_apb_completer_mem;

  localparam int          NDUT = 3;
  localparam int          WS_TAB   [NDUT] = '{1, 0, 3};
  localparam logic [31:0] BASE_TAB [NDUT] = '{32'h0000_0100, 32'h0000_0000, 32'h0000_0000};

  logic        clk;
  logic        rst;
  logic        psel    [NDUT];
  logic        penable [NDUT];
  logic        pwrite  [NDUT];
  logic [31:0] paddr   [NDUT];
  logic [31:0] pwdata  [NDUT];
  logic [3:0]  pstrb   [NDUT];
  logic        pready  [NDUT];
  logic [31:0] prdata  [NDUT];
  logic        pslverr [NDUT];

  logic [31:0] model [NDUT][16];
  int total;
  int bad;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    apb_completer_mem #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .DEPTH       (16),
      .BASE_ADDR   (BASE_TAB[g]),
      .WAIT_STATES (WS_TAB[g])
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .psel    (psel[g]),
      .penable (penable[g]),
      .pwrite  (pwrite[g]),
      .paddr   (paddr[g]),
      .pwdata  (pwdata[g]),
`ifdef APB_COMPLETER_PSTRB_EN
      .pstrb   (pstrb[g]),
`endif
      .pready  (pready[g]),
      .prdata  (prdata[g]),
      .pslverr (pslverr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: 64-byte window at the instance base, word aligned.
  function automatic logic m_err(input int d, input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE_TAB[d];
    return (o >= 32'd64) || (a[1:0] != 2'b00);
  endfunction

  function automatic int m_idx(input int d, input logic [31:0] a);
    logic [31:0] o;
    o = (a - BASE_TAB[d]) >> 2;
    return int'(o[3:0]);
  endfunction

  function automatic logic [31:0] rand_addr(input int d);
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7) return BASE_TAB[d] + 32'(4 * $urandom_range(0, 15));
    if (r == 7) return BASE_TAB[d] + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
    if (r == 8) return BASE_TAB[d] + 32'd64 + 32'(4 * $urandom_range(0, 15));
    return BASE_TAB[d] - 32'd4;
  endfunction

  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input string tag);
    int          lat;
    logic        err;
    int          idx;
    logic [3:0]  s_eff;
    err = m_err(d, addr);
    idx = m_idx(d, addr);
`ifdef APB_COMPLETER_PSTRB_EN
    s_eff = strb;
`else
    s_eff = 4'hF;
`endif
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = data; pstrb[d] = strb;
    @(negedge clk);
    chk({tag, ".setup_pready"}, 32'(pready[d]), 32'd0);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    lat = 1;
    @(negedge clk);
    while (!pready[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(WS_TAB[d] + 1));
    chk({tag, ".pslverr"}, 32'(pslverr[d]), 32'(err));
    if (!wr) begin
      chk({tag, ".prdata"}, prdata[d], err ? 32'd0 : model[d][idx]);
    end else if (!err) begin
      for (int b = 0; b < 4; b++) begin
        if (s_eff[b]) model[d][idx][b*8 +: 8] = data[b*8 +: 8];
      end
    end
  endtask

  task automatic idle(input int d, input int n);
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic clear_model();
    for (int d = 0; d < NDUT; d++) begin
      for (int w = 0; w < 16; w++) model[d][w] = 32'd0;
    end
  endtask

  initial begin
    int          d;
    logic        wr;
    logic [31:0] a;
    logic [31:0] dat;
    logic [3:0]  s;

    total = 0;
    bad   = 0;
    clear_model();
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = '0; pwdata[i] = '0; pstrb[i] = 4'hF;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("reset.pready%0d", i), 32'(pready[i]), 32'd0);
      chk($sformatf("reset.pslverr%0d", i), 32'(pslverr[i]), 32'd0);
      chk($sformatf("reset.prdata%0d", i), prdata[i], 32'd0);
    end

    // Basic write then readback, one wait state.
    xfer(0, 1'b1, 32'h0000_0108, 32'hDEAD_BEEF, 4'hF, "ws1_wr");
    idle(0, 2);
    xfer(0, 1'b0, 32'h0000_0108, 32'h0, 4'hF, "ws1_rd");
    chk("ws1_rd.const", prdata[0], 32'hDEAD_BEEF);
    idle(0, 1);

    // Zero-wait back-to-back, no idle cycles between transfers.
    xfer(1, 1'b1, 32'h0, 32'h1111_2222, 4'hF, "b2b_wr0");
    xfer(1, 1'b0, 32'h4, 32'h0, 4'hF, "b2b_rd4");
    xfer(1, 1'b1, 32'h0, 32'h3333_4444, 4'hF, "b2b_wr0b");
    xfer(1, 1'b0, 32'h0, 32'h0, 4'hF, "b2b_rd0");
    chk("b2b_rd0.const", prdata[1], 32'h3333_4444);
    idle(1, 1);

    // Error responses leave the array alone.
    xfer(0, 1'b0, 32'h0000_0140, 32'h0, 4'hF, "err_rd_hi");
    xfer(0, 1'b1, 32'h0000_0102, 32'h5555_AAAA, 4'hF, "err_wr_mis");
    xfer(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, "err_reread");
    xfer(0, 1'b1, 32'h0000_00FC, 32'h7777_7777, 4'hF, "err_wr_lo");
    xfer(0, 1'b0, 32'h0000_013C, 32'h0, 4'hF, "edge_rd_top");
    idle(0, 1);

`ifdef APB_COMPLETER_PSTRB_EN
    xfer(1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, "strb_full");
    xfer(1, 1'b1, 32'h10, 32'h1234_5678, 4'b0101, "strb_part");
    xfer(1, 1'b1, 32'h10, 32'h0000_0000, 4'b0000, "strb_none");
    xfer(1, 1'b0, 32'h10, 32'h0, 4'hF, "strb_rd");
    chk("strb_rd.const", prdata[1], 32'hFF34_FF78);
    idle(1, 1);
`endif

    // Abort: drop psel during the wait states of a write.
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 32'h8; pwdata[2] = 32'hA5A5_A5A5; pstrb[2] = 4'hF;
    @(posedge clk); #1 penable[2] = 1'b1;
    @(posedge clk); #1 psel[2] = 1'b0; penable[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("abort.pready_c%0d", k), 32'(pready[2]), 32'd0);
    end
    xfer(2, 1'b0, 32'h8, 32'h0, 4'hF, "abort_rd");
    chk("abort_rd.const", prdata[2], 32'd0);
    idle(2, 1);

    // Randomised traffic on all three instances.
    for (int n = 0; n < 120; n++) begin
      d   = (n < 60) ? 0 : ((n < 95) ? 1 : 2);
      wr  = 1'($urandom_range(0, 1));
      a   = rand_addr(d);
      dat = $urandom;
      s   = 4'($urandom_range(0, 15));
      xfer(d, wr, a, dat, s, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 3) == 0) idle(d, int'($urandom_range(1, 2)));
    end
    for (int i = 0; i < NDUT; i++) idle(i, 1);

    // Reset in the access cycle of a read.
    xfer(0, 1'b1, 32'h0000_010C, 32'hCAFE_F00D, 4'hF, "pre_rst_wr");
    idle(0, 1);
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 32'h0000_010C;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.pready_c1", 32'(pready[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    psel[0] = 1'b0; penable[0] = 1'b0;
    clear_model();
    @(negedge clk);
    chk("rst_mid.pready_c2", 32'(pready[0]), 32'd0);
    for (int w = 0; w < 16; w++) begin
      xfer(0, 1'b0, BASE_TAB[0] + 32'(4 * w), 32'h0, 4'hF, $sformatf("post_rst_w%0d", w));
      chk($sformatf("post_rst_w%0d.zero", w), prdata[0], 32'd0);
    end
    idle(0, 1);
    xfer(1, 1'b0, 32'h0, 32'h0, 4'hF, "post_rst_d1");
    idle(1, 1);
    xfer(2, 1'b0, 32'h8, 32'h0, 4'hF, "post_rst_d2");
    idle(2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
